// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory bus between the fetch stage (master) and an async-read imem (slave).
interface instr_fetch_unit_if #(
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_rdata;

  modport master (output imem_addr, input imem_rdata);
  modport slave  (input imem_addr, output imem_rdata);
endinterface

// File: rtl/instr_fetch_unit.sv
// IF stage: owns the PC, captures imem words into IF/ID and squashes the
// wrong-path fetch behind a jr/j redirect resolved in ID.
module instr_fetch_unit #(
  parameter int              ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              jr,
  input  logic [ADDR_W-1:0] jr_target,
  input  logic              j,
  instr_fetch_unit_if.master imem,
  output logic [31:0]       ins,
  output logic [ADDR_W-1:0] ins_pc4,
  output logic              ins_valid,
  output logic              misalign,
  output logic              fsm_state
);

  // Handshake: no valid/ready; ins is meaningful only while ins_valid=1, and
  // stall freezes every register except misalign, which clears.
  typedef enum logic {SQUASH = 1'b0, RUN = 1'b1} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       ins_q, ins_d;
  logic [ADDR_W-1:0] ins_pc4_q, ins_pc4_d;
  logic              misalign_q, misalign_d;

  logic [ADDR_W-1:0] pc4;
  logic [ADDR_W-1:0] jr_tgt;
  logic [ADDR_W-1:0] j_tgt;
  logic              redirect;

  assign pc4    = pc_q + ADDR_W'(4);
  assign jr_tgt = {jr_target[ADDR_W-1:2], 2'b00};

  // Narrow PCs have no region bits above the 28-bit j span; the index is truncated.
  if (ADDR_W > 28) begin : g_j_wide
    assign j_tgt = {ins_pc4_q[ADDR_W-1:28], ins_q[25:0], 2'b00};
  end else begin : g_j_narrow
    assign j_tgt = ADDR_W'({ins_q[25:0], 2'b00});
  end

  // A bubble in ID cannot hold a real jump, so requests are dropped in SQUASH.
  assign redirect = (state_q == RUN) && (jr || j);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ins_d      = ins_q;
    ins_pc4_d  = ins_pc4_q;
    misalign_d = 1'b0;
    if (!stall) begin
      if (redirect) begin
        pc_d       = jr ? jr_tgt : j_tgt;
        ins_d      = '0;
        ins_pc4_d  = '0;
        state_d    = SQUASH;
        misalign_d = jr && (jr_target[1:0] != 2'b00);
      end else begin
        pc_d      = pc4;
        ins_d     = imem.imem_rdata;
        ins_pc4_d = pc4;
        state_d   = RUN;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= SQUASH;
      pc_q       <= RESET_PC;
      ins_q      <= '0;
      ins_pc4_q  <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ins_q      <= ins_d;
      ins_pc4_q  <= ins_pc4_d;
      misalign_q <= misalign_d;
    end
  end

  assign imem.imem_addr = pc_q;
  assign ins            = ins_q;
  assign ins_pc4        = ins_pc4_q;
  assign ins_valid      = (state_q == RUN);
  assign misalign       = misalign_q;
  assign fsm_state      = state_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus random traffic against a
// cycle-level reference model, and a narrow 8-bit PC instance for wrap/reset.
module tb_instr_fetch_unit;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- 32-bit DUT ----------------
  logic        rst = 1'b1, stall = 1'b0, jr = 1'b0, j = 1'b0;
  logic [31:0] jr_target = '0;
  logic [31:0] ins, ins_pc4;
  logic        ins_valid, misalign, fsm_state;

  logic [31:0] mem_key = '0;
  logic        ovr_en = 1'b0;
  logic [31:0] ovr_addr = '0, ovr_data = '0;

  instr_fetch_unit_if #(.ADDR_W(32)) m_if ();
  assign m_if.imem_rdata = (ovr_en && m_if.imem_addr == ovr_addr) ? ovr_data
                                                                  : (m_if.imem_addr ^ mem_key);

  instr_fetch_unit #(.ADDR_W(32), .RESET_PC(32'h40)) dut (
    .clk(clk), .rst(rst), .stall(stall), .jr(jr), .jr_target(jr_target), .j(j),
    .imem(m_if.master), .ins(ins), .ins_pc4(ins_pc4), .ins_valid(ins_valid),
    .misalign(misalign), .fsm_state(fsm_state)
  );

  // ---------------- 8-bit DUT ----------------
  logic       s_rst = 1'b1, s_stall = 1'b0, s_jr = 1'b0, s_j = 1'b0;
  logic [7:0] s_tgt = '0;
  logic [31:0] s_ins;
  logic [7:0] s_ins_pc4;
  logic       s_valid, s_mis, s_state;

  instr_fetch_unit_if #(.ADDR_W(8)) s_if ();
  assign s_if.imem_rdata = {24'hAB0000, s_if.imem_addr};

  instr_fetch_unit #(.ADDR_W(8), .RESET_PC(8'hF0)) dut8 (
    .clk(clk), .rst(s_rst), .stall(s_stall), .jr(s_jr), .jr_target(s_tgt), .j(s_j),
    .imem(s_if.master), .ins(s_ins), .ins_pc4(s_ins_pc4), .ins_valid(s_valid),
    .misalign(s_mis), .fsm_state(s_state)
  );

  // ---------------- checker ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- reference model / scoreboard ----------------
  logic [31:0] m_pc, m_ins, m_pc4;
  logic        m_valid, m_mis;
  logic        m_known = 1'b0;
  logic [31:0] exp_q[$];

  function automatic logic [31:0] mem_model(input logic [31:0] a);
    if (ovr_en && a == ovr_addr) return ovr_data;
    return a ^ mem_key;
  endfunction

  // Called just after a falling edge: applies inputs, predicts the next
  // IF/ID contents, then checks them after the following falling edge.
  task automatic drive(input logic r, input logic s, input logic do_jr,
                       input logic [31:0] tgt, input logic do_j);
    logic [31:0] n_pc, n_ins, n_pc4;
    logic        n_valid, n_mis;
    rst = r; stall = s; jr = do_jr; jr_target = tgt; j = do_j;
    #1;
    if (m_known) check_eq("imem_addr", m_if.imem_addr, m_pc);
    if (r) begin
      n_pc = 32'h40; n_ins = '0; n_pc4 = '0; n_valid = 1'b0; n_mis = 1'b0;
    end else if (s) begin
      n_pc = m_pc; n_ins = m_ins; n_pc4 = m_pc4; n_valid = m_valid; n_mis = 1'b0;
    end else if (m_valid && (do_jr || do_j)) begin
      n_pc    = do_jr ? (tgt & 32'hFFFF_FFFC) : {m_pc4[31:28], m_ins[25:0], 2'b00};
      n_ins   = '0; n_pc4 = '0; n_valid = 1'b0;
      n_mis   = do_jr && (tgt % 4 != 0);
    end else begin
      n_pc = m_pc + 32'd4; n_ins = mem_model(m_pc); n_pc4 = m_pc + 32'd4;
      n_valid = 1'b1; n_mis = 1'b0;
    end
    exp_q.push_back(n_ins);
    m_pc = n_pc; m_pc4 = n_pc4; m_valid = n_valid; m_mis = n_mis; m_ins = n_ins;
    m_known = m_known | r;
    @(negedge clk);
    check_eq("ins", ins, exp_q.pop_front());
    check_eq("ins_pc4", ins_pc4, m_pc4);
    check_eq("ins_valid", {31'b0, ins_valid}, {31'b0, m_valid});
    check_eq("misalign", {31'b0, misalign}, {31'b0, m_mis});
    check_eq("fsm_state", {31'b0, fsm_state}, {31'b0, m_valid});
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    @(negedge clk);
    // reset, then straight-line fetch with data == address
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 32'h80, 1'b1);
    check_eq("rst_addr", m_if.imem_addr, 32'h40);
    run(1);
    check_eq("first_ins", ins, 32'h40);
    check_eq("first_pc4", ins_pc4, 32'h44);
    run(2);
    check_eq("third_addr", m_if.imem_addr, 32'h4C);

    // jr at pc=0x20 to 0x100
    drive(1'b0, 1'b0, 1'b1, 32'h1C, 1'b0);
    run(1);
    check_eq("pc_at_20", m_if.imem_addr, 32'h20);
    drive(1'b0, 1'b0, 1'b1, 32'h100, 1'b0);
    check_eq("jr_addr", m_if.imem_addr, 32'h100);
    check_eq("jr_bubble", {ins_valid, ins[30:0]}, 32'h0);
    run(1);
    check_eq("jr_land", ins, 32'h100);

    // j with ins=0x0800_0010 and ins_pc4=0x1000_0008
    ovr_en = 1'b1; ovr_addr = 32'h1000_0004; ovr_data = 32'h0800_0010;
    drive(1'b0, 1'b0, 1'b1, 32'h1000_0004, 1'b0);
    run(1);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    check_eq("j_addr", m_if.imem_addr, 32'h1000_0040);
    ovr_en = 1'b0;
    run(1);

    // stall 3 cycles at pc=0x30 with jr held, then jr is taken
    drive(1'b0, 1'b0, 1'b1, 32'h2C, 1'b0);
    run(1);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b1, 32'h80, 1'b0);
    check_eq("stall_addr", m_if.imem_addr, 32'h30);
    drive(1'b0, 1'b0, 1'b1, 32'h80, 1'b0);
    check_eq("post_stall_addr", m_if.imem_addr, 32'h80);

    // jr and j together, misaligned target
    run(1);
    drive(1'b0, 1'b0, 1'b1, 32'h203, 1'b1);
    check_eq("prio_addr", m_if.imem_addr, 32'h200);
    check_eq("mis_pulse", {31'b0, misalign}, 32'h1);
    run(1);
    check_eq("mis_clear", {31'b0, misalign}, 32'h0);

    // random traffic
    mem_key = $urandom;
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 49) == 0, $urandom_range(0, 4) == 0,
            $urandom_range(0, 9) == 0, $urandom, $urandom_range(0, 9) == 0);
    end

    // 8-bit PC: wrap at 0xFC, then reset during a stall
    s_rst = 1'b1;
    @(negedge clk);
    check_eq("n_rst_addr", {24'b0, s_if.imem_addr}, 32'hF0);
    check_eq("n_rst_ins", s_ins, 32'h0);
    s_rst = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("n_wrap_addr", {24'b0, s_if.imem_addr}, 32'h00);
    check_eq("n_wrap_ins", s_ins, 32'hAB0000FC);
    check_eq("n_wrap_pc4", {24'b0, s_ins_pc4}, 32'h00);
    check_eq("n_wrap_mis", {31'b0, s_mis}, 32'h0);
    s_stall = 1'b1;
    @(negedge clk);
    check_eq("n_stall_ins", s_ins, 32'hAB0000FC);
    s_rst = 1'b1;
    @(negedge clk);
    check_eq("n_rst2_addr", {24'b0, s_if.imem_addr}, 32'hF0);
    check_eq("n_rst2_ins", s_ins, 32'h0);
    check_eq("n_rst2_pc4", {24'b0, s_ins_pc4}, 32'h0);
    check_eq("n_rst2_valid", {31'b0, s_valid}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
